// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and defaults used by the register file.
package mips_pkg;

    // Register-file clear sequencer states
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

endpackage : mips_pkg

// File: rtl/reg_file_mp_read_port.sv
// One combinational read lane: array lookup, write-to-read bypass and
// zero-register / busy masking.
module rf_read_port #(
    parameter int DW      = 32,
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic [DW-1:0] i_mem [DEPTH],
    input  logic [AW-1:0] i_addr,
    input  logic          i_busy,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  logic [DW-1:0] i_wd1,
    input  logic          i_we2,
    input  logic [AW-1:0] i_wa2,
    input  logic [DW-1:0] i_wd2,
    output logic [DW-1:0] o_data
);

    // Select stored data, override with in-flight writes (port 2 last so it
    // wins), then force zero for r0 and while the clear sequencer runs.
    // Write enables arrive already qualified: RUN state, no clear, not a
    // discarded r0 write.
    always_comb begin
        o_data = i_mem[i_addr];
        if (BYPASS != 0) begin
            if (i_we1 && (i_wa1 == i_addr)) o_data = i_wd1;
            if (i_we2 && (i_wa2 == i_addr)) o_data = i_wd2;
        end
        if ((ZERO_R0 != 0) && (i_addr == '0)) o_data = '0;
        if (i_busy) o_data = '0;
    end

endmodule : rf_read_port

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file: NRD combinational reads, two synchronous
// writes, built-in clear sequencer that zeroes the array after reset or on
// REG_clr and holds REG_busy high while doing so.
module reg_file_mp
    import mips_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int DEPTH   = RF_DEPTH,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              SYS_clk,
    input  logic              SYS_rst_n,
    input  logic              REG_clr,
    input  logic [NRD*AW-1:0] REG_address_rd,
    output logic [NRD*DW-1:0] REG_data_out,
    input  logic              REG_write_1,
    input  logic              REG_write_2,
    input  logic [AW-1:0]     REG_address_wr1,
    input  logic [AW-1:0]     REG_address_wr2,
    input  logic [DW-1:0]     REG_data_wb_in1,
    input  logic [DW-1:0]     REG_data_wb_in2,
    output logic              REG_busy
);

    rf_state_t       r_state;
    logic [AW-1:0]   r_ctr;
    logic [DW-1:0]   r_mem [DEPTH];

    rf_state_t       w_state_nx;
    logic [AW-1:0]   w_ctr_nx;
    logic            w_clr_wr;
    logic            w_we1;
    logic            w_we2;

    // Qualified write enables: only in RUN, dropped when a clear is requested,
    // and r0 writes discarded when the zero register is hard-wired.
    assign w_we1 = (r_state == RUN) && !REG_clr && REG_write_1 &&
                   !((ZERO_R0 != 0) && (REG_address_wr1 == '0));
    assign w_we2 = (r_state == RUN) && !REG_clr && REG_write_2 &&
                   !((ZERO_R0 != 0) && (REG_address_wr2 == '0));

    assign REG_busy = (r_state == CLEAR);

    // Next-state logic for the clear sequencer; REG_clr restarts from entry 0
    // in either state.
    always_comb begin
        w_state_nx = r_state;
        w_ctr_nx   = r_ctr;
        w_clr_wr   = 1'b0;
        if (REG_clr) begin
            w_state_nx = CLEAR;
            w_ctr_nx   = '0;
        end else if (r_state == CLEAR) begin
            w_clr_wr = 1'b1;
            w_ctr_nx = AW'(r_ctr + 1'b1);
            if (r_ctr == AW'(DEPTH - 1)) begin
                w_state_nx = RUN;
            end
        end
    end

    // State register plus array update; the array itself has no reset and is
    // only written by the clear sequencer or the two write ports.
    always_ff @(posedge SYS_clk or negedge SYS_rst_n) begin
        if (!SYS_rst_n) begin
            r_state <= CLEAR;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ctr   <= w_ctr_nx;
            if (w_clr_wr) r_mem[r_ctr] <= '0;
            if (w_we1) r_mem[REG_address_wr1] <= REG_data_wb_in1;
            if (w_we2) r_mem[REG_address_wr2] <= REG_data_wb_in2;
        end
    end

    // One read lane per port
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .DW      (DW),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_rd (
            .i_mem  (r_mem),
            .i_addr (REG_address_rd[k*AW +: AW]),
            .i_busy (REG_busy),
            .i_we1  (w_we1),
            .i_wa1  (REG_address_wr1),
            .i_wd1  (REG_data_wb_in1),
            .i_we2  (w_we2),
            .i_wa2  (REG_address_wr2),
            .i_wd2  (REG_data_wb_in2),
            .o_data (REG_data_out[k*DW +: DW])
        );
    end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with bypass, one without,
// driven by the same stimulus.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [9:0]  rd_addr;
    logic [63:0] dout_bp;
    logic [63:0] dout_nb;
    logic        we1, we2;
    logic [4:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic        busy_bp, busy_nb;

    int n_checks = 0;
    int n_err    = 0;
    int cnt;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(32), .DEPTH(32), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dut (
        .SYS_clk(clk), .SYS_rst_n(rst_n), .REG_clr(clr),
        .REG_address_rd(rd_addr), .REG_data_out(dout_bp),
        .REG_write_1(we1), .REG_write_2(we2),
        .REG_address_wr1(wa1), .REG_address_wr2(wa2),
        .REG_data_wb_in1(wd1), .REG_data_wb_in2(wd2),
        .REG_busy(busy_bp)
    );

    reg_file_mp #(.DW(32), .DEPTH(32), .NRD(2), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .SYS_clk(clk), .SYS_rst_n(rst_n), .REG_clr(clr),
        .REG_address_rd(rd_addr), .REG_data_out(dout_nb),
        .REG_write_1(we1), .REG_write_2(we2),
        .REG_address_wr1(wa1), .REG_address_wr2(wa2),
        .REG_data_wb_in1(wd1), .REG_data_wb_in2(wd2),
        .REG_busy(busy_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; rd_addr = '0;
        we1 = 1'b0; we2 = 1'b0; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;

        // Reset held low for 3 cycles
        set_rd(5'd4, 5'd9);
        tick(); tick(); tick();
        chk("rst_busy", {31'd0, busy_bp}, 32'd1);
        chk("rst_lane0", dout_bp[31:0], 32'd0);
        chk("rst_lane1", dout_bp[63:32], 32'd0);
        rst_n = 1'b1;

        // Clear after reset: busy for exactly 32 edges
        cnt = 0;
        while (busy_bp && cnt < 100) begin
            if (cnt == 10) chk("clr_lane_busy", dout_bp[31:0], 32'd0);
            tick();
            cnt++;
        end
        chk("rst_clear_len", cnt, 32'd32);
        chk("nb_busy_low", {31'd0, busy_nb}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            chk($sformatf("post_clr_r%0d", a), dout_bp[31:0], 32'd0);
        end

        // Basic write/read on both ports
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'd13;
        we2 = 1'b1; wa2 = 5'd11; wd2 = 32'd18;
        set_rd(5'd20, 5'd21);
        tick();
        we1 = 1'b0; we2 = 1'b0;
        set_rd(5'd10, 5'd11);
        #1;
        chk("basic_r10", dout_bp[31:0], 32'd13);
        chk("basic_r11", dout_bp[63:32], 32'd18);
        chk("basic_nb_r10", dout_nb[31:0], 32'd13);

        // Same-address conflict: port 2 wins (also in bypass)
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hAAAA_AAAA;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h5555_5555;
        set_rd(5'd7, 5'd10);
        #1;
        chk("conf_bypass", dout_bp[31:0], 32'h5555_5555);
        chk("conf_nb_old", dout_nb[31:0], 32'd0);
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("conf_r7", dout_bp[31:0], 32'h5555_5555);
        chk("conf_nb_r7", dout_nb[31:0], 32'h5555_5555);

        // Bypass versus no bypass
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_1234;
        set_rd(5'd3, 5'd7);
        #1;
        chk("byp_same_cycle", dout_bp[31:0], 32'h0000_1234);
        chk("nobyp_old", dout_nb[31:0], 32'd0);
        chk("byp_other_lane", dout_bp[63:32], 32'h5555_5555);
        tick();
        we1 = 1'b0;
        #1;
        chk("nobyp_after", dout_nb[31:0], 32'h0000_1234);

        // Zero register: writes discarded, no bypass of r0
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        we2 = 1'b1; wa2 = 5'd0; wd2 = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd0);
        #1;
        chk("r0_bypass", dout_bp[31:0], 32'd0);
        chk("r0_bypass_p1", dout_bp[63:32], 32'd0);
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("r0_direct", dout_bp[31:0], 32'd0);
        chk("r0_nb_direct", dout_nb[31:0], 32'd0);

        // Fill r1..r31, then soft clear together with a write to r5
        for (int i = 1; i < 32; i++) begin
            we1 = 1'b1; wa1 = 5'(i); wd1 = 32'h0000_1000 + 32'(i);
            tick();
        end
        we1 = 1'b0;
        set_rd(5'd5, 5'd31);
        #1;
        chk("fill_r5", dout_bp[31:0], 32'h0000_1005);
        chk("fill_r31", dout_bp[63:32], 32'h0000_101F);
        clr = 1'b1;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'd99;
        tick();
        clr = 1'b0; we1 = 1'b0;
        cnt = 0;
        while (busy_bp && cnt < 100) begin
            chk("sclr_lane0", dout_bp[31:0], 32'd0);
            chk("sclr_lane1", dout_bp[63:32], 32'd0);
            tick();
            cnt++;
        end
        chk("sclr_len", cnt, 32'd32);
        chk("sclr_r5", dout_bp[31:0], 32'd0);
        chk("sclr_r31", dout_bp[63:32], 32'd0);
        chk("sclr_nb_r5", dout_nb[31:0], 32'd0);

        // Writes work again after the clear
        we2 = 1'b1; wa2 = 5'd5; wd2 = 32'hCAFE_0005;
        tick();
        we2 = 1'b0;
        #1;
        chk("post_sclr_wr", dout_nb[31:0], 32'hCAFE_0005);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_reg_file_mp
